// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the five-stage
// RISC-V core. It holds fetch for one cycle after reset and inserts ID/EX
// bubbles for load-use hazards, LOAD_LAT cycles per hazard. On a taken branch
// it flushes IF/ID and ID/EX. On an outstanding data-memory access it freezes
// the back end.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   IF_ID_inst_opcode     opcode of the instruction in ID
//   IF_ID_rs1/IF_ID_rs2   source registers of the instruction in ID
//   ID_EX_mem_read/rd     load flag and destination of the instruction in EX
//   branch_taken          EX redirects the PC
//   imem_ready            instruction memory has valid data this cycle
//   dmem_req/dmem_ready   MEM-stage access and its completion
//   pc_write, IF_ID_write, IF_flush, ID_EX_flush, pipe_freeze
//                         pipeline control (combinational, Mealy)
//   ctrl_state            current FSM state for debug
//
// Optional feature: define RISCV_HAZARD_PERF_EN to add the saturating
// performance counters perf_lu_cnt, perf_flush_cnt and perf_freeze_cnt,
// each CNT_WIDTH bits wide.

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module hazard_ctrl #(
   parameter int unsigned REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
   parameter int unsigned LOAD_LAT       = 1,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [6:0]                IF_ID_inst_opcode,
   input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
   input  logic                      ID_EX_mem_read,
   input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
   input  logic                      branch_taken,
   input  logic                      imem_ready,
   input  logic                      dmem_req,
   input  logic                      dmem_ready,
   output logic                      pc_write,
   output logic                      IF_ID_write,
   output logic                      IF_flush,
   output logic                      ID_EX_flush,
   output logic                      pipe_freeze,
   output logic [1:0]                ctrl_state
`ifdef RISCV_HAZARD_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0]      perf_lu_cnt,
   output logic [CNT_WIDTH-1:0]      perf_flush_cnt,
   output logic [CNT_WIDTH-1:0]      perf_freeze_cnt
`endif
);

   localparam int unsigned STALL_W = 4;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // The first stall cycle is spent in RUN and the last in LU_STALL with a
   // count of 0, so the reload value is LOAD_LAT-2.
   localparam bit                 LU_MULTI  = (LOAD_LAT > 1);
   localparam logic [STALL_W-1:0] LU_RELOAD =
      (LOAD_LAT > 1) ? STALL_W'(LOAD_LAT - 2) : '0;

   // Elaboration-time parameter range check
   if (LOAD_LAT < 1 || LOAD_LAT > 15 || CNT_WIDTH < 1) begin : g_param_check
      $error("hazard_ctrl: LOAD_LAT must be 1..15 and CNT_WIDTH at least 1");
   end

   typedef enum logic [1:0] {
      ST_INIT     = 2'b00,
      ST_RUN      = 2'b01,
      ST_LU_STALL = 2'b10,
      ST_UNUSED   = 2'b11
   } state_e;

   state_e             state_q, state_d;
   logic [STALL_W-1:0] cnt_q, cnt_d;

   logic use_rs1;
   logic use_rs2;
   logic lu;
   logic freeze;

   // Which source registers the ID instruction actually reads
   always_comb begin
      use_rs1 = 1'b1;
      use_rs2 = 1'b0;
      case (IF_ID_inst_opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL: use_rs1 = 1'b0;
         default: ;
      endcase
      case (IF_ID_inst_opcode)
         OPC_OP, OPC_STORE, OPC_BRANCH: use_rs2 = 1'b1;
         default: ;
      endcase
   end

   // Load in EX writes a register the ID instruction reads (x0 never hazards)
   assign lu = ID_EX_mem_read
             && (ID_EX_rd != '0)
             && ((use_rs1 && (ID_EX_rd == IF_ID_rs1))
              || (use_rs2 && (ID_EX_rd == IF_ID_rs2)));

   assign freeze      = dmem_req & ~dmem_ready;
   assign pipe_freeze = freeze;
   assign ctrl_state  = state_q;

   // State and stall-count registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and prioritised output decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      IF_flush    = 1'b0;
      ID_EX_flush = 1'b0;

      case (state_q)
         ST_INIT: begin
            IF_flush    = 1'b1;
            ID_EX_flush = 1'b1;
            cnt_d       = '0;
            state_d     = ST_RUN;
         end

         ST_RUN, ST_LU_STALL: begin
            if (freeze) begin
               // Whole pipe holds; state and count are preserved
               state_d = state_q;
            end else if (branch_taken) begin
               pc_write    = 1'b1;
               IF_ID_write = 1'b1;
               IF_flush    = 1'b1;
               ID_EX_flush = 1'b1;
               cnt_d       = '0;
               state_d     = ST_RUN;
            end else if (state_q == ST_LU_STALL) begin
               ID_EX_flush = 1'b1;
               if (cnt_q == '0) begin
                  state_d = ST_RUN;
               end else begin
                  cnt_d = cnt_q - STALL_W'(1);
               end
            end else if (lu) begin
               ID_EX_flush = 1'b1;
               if (LU_MULTI) begin
                  cnt_d   = LU_RELOAD;
                  state_d = ST_LU_STALL;
               end
            end else if (!imem_ready) begin
               // Fetch miss: keep the PC, feed a bubble into ID
               IF_ID_write = 1'b1;
               IF_flush    = 1'b1;
            end else begin
               pc_write    = 1'b1;
               IF_ID_write = 1'b1;
            end
         end

         default: begin
            // Unreachable encoding: bubble the front end and recover to RUN
            IF_flush    = 1'b1;
            ID_EX_flush = 1'b1;
            cnt_d       = '0;
            state_d     = ST_RUN;
         end
      endcase
   end

`ifdef RISCV_HAZARD_PERF_EN
   logic lu_act;
   logic flush_act;
   logic freeze_act;

   // Load-use stall is the only decode with ID_EX_flush but no IF_flush;
   // a branch flush is the only decode with both pc_write and IF_flush.
   assign lu_act     = ID_EX_flush & ~IF_flush;
   assign flush_act  = pc_write & IF_flush;
   assign freeze_act = freeze & ((state_q == ST_RUN) || (state_q == ST_LU_STALL));

   // Saturating event counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_lu_cnt     <= '0;
         perf_flush_cnt  <= '0;
         perf_freeze_cnt <= '0;
      end else begin
         if (lu_act && (perf_lu_cnt != '1)) begin
            perf_lu_cnt <= perf_lu_cnt + CNT_WIDTH'(1);
         end
         if (flush_act && (perf_flush_cnt != '1)) begin
            perf_flush_cnt <= perf_flush_cnt + CNT_WIDTH'(1);
         end
         if (freeze_act && (perf_freeze_cnt != '1)) begin
            perf_freeze_cnt <= perf_freeze_cnt + CNT_WIDTH'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Two instances (LOAD_LAT = 1 and 3) share the
// same stimulus. Expected outputs come from a reference model that tracks
// the remaining stall cycles. They are queued when stimulus is applied and
// compared shortly after.

module tb_hazard_ctrl;

   localparam logic [6:0] ADD  = 7'b0110011;
   localparam logic [6:0] ADDI = 7'b0010011;
   localparam logic [6:0] LUI  = 7'b0110111;

   typedef struct packed {
      logic       pc_write;
      logic       if_id_write;
      logic       if_flush;
      logic       id_ex_flush;
      logic       pipe_freeze;
      logic [1:0] state;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [6:0] opcode;
   logic [4:0] rs1, rs2, rd;
   logic       mem_read, branch_taken, imem_ready, dmem_req, dmem_ready;

   logic       pcw1, ifw1, iff1, idf1, frz1;
   logic [1:0] st1;
   logic       pcw3, ifw3, iff3, idf3, frz3;
   logic [1:0] st3;
`ifdef RISCV_HAZARD_PERF_EN
   logic [31:0] plu1, pfl1, pfz1, plu3, pfl3, pfz3;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   int   rem1, rem3;
   bit   init_m;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_ADDR_WIDTH(5), .LOAD_LAT(1), .CNT_WIDTH(32)) u_lat1 (
      .clk(clk), .reset_n(reset_n),
      .IF_ID_inst_opcode(opcode), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
      .ID_EX_mem_read(mem_read), .ID_EX_rd(rd),
      .branch_taken(branch_taken), .imem_ready(imem_ready),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pcw1), .IF_ID_write(ifw1), .IF_flush(iff1),
      .ID_EX_flush(idf1), .pipe_freeze(frz1), .ctrl_state(st1)
`ifdef RISCV_HAZARD_PERF_EN
      , .perf_lu_cnt(plu1), .perf_flush_cnt(pfl1), .perf_freeze_cnt(pfz1)
`endif
   );

   hazard_ctrl #(.REG_ADDR_WIDTH(5), .LOAD_LAT(3), .CNT_WIDTH(32)) u_lat3 (
      .clk(clk), .reset_n(reset_n),
      .IF_ID_inst_opcode(opcode), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
      .ID_EX_mem_read(mem_read), .ID_EX_rd(rd),
      .branch_taken(branch_taken), .imem_ready(imem_ready),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pcw3), .IF_ID_write(ifw3), .IF_flush(iff3),
      .ID_EX_flush(idf3), .pipe_freeze(frz3), .ctrl_state(st3)
`ifdef RISCV_HAZARD_PERF_EN
      , .perf_lu_cnt(plu3), .perf_flush_cnt(pfl3), .perf_freeze_cnt(pfz3)
`endif
   );

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Reference model: rem = stall cycles still to be served after this one
   function automatic exp_t model(input bit init, input int rem, input int lat,
                                  output int rem_n);
      exp_t e;
      bit   u1, u2, lu, frz;
      u1 = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
      u2 = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
      lu = mem_read && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
      frz = dmem_req && !dmem_ready;
      e.pipe_freeze = frz;
      rem_n = rem;
      if (init) begin
         e.state = 2'b00;
         {e.pc_write, e.if_id_write, e.if_flush, e.id_ex_flush} = 4'b0011;
         rem_n = 0;
      end else begin
         e.state = (rem > 0) ? 2'b10 : 2'b01;
         if (frz) begin
            {e.pc_write, e.if_id_write, e.if_flush, e.id_ex_flush} = 4'b0000;
         end else if (branch_taken) begin
            {e.pc_write, e.if_id_write, e.if_flush, e.id_ex_flush} = 4'b1111;
            rem_n = 0;
         end else if (rem > 0) begin
            {e.pc_write, e.if_id_write, e.if_flush, e.id_ex_flush} = 4'b0001;
            rem_n = rem - 1;
         end else if (lu) begin
            {e.pc_write, e.if_id_write, e.if_flush, e.id_ex_flush} = 4'b0001;
            rem_n = lat - 1;
         end else if (!imem_ready) begin
            {e.pc_write, e.if_id_write, e.if_flush, e.id_ex_flush} = 4'b0110;
         end else begin
            {e.pc_write, e.if_id_write, e.if_flush, e.id_ex_flush} = 4'b1100;
         end
      end
      return e;
   endfunction

   task automatic check_dut(input string tag, input string which, input exp_t obs);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "/", which, "/sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "/", which, "/pc_write"},    32'(obs.pc_write),    32'(e.pc_write));
      chk({tag, "/", which, "/IF_ID_write"}, 32'(obs.if_id_write), 32'(e.if_id_write));
      chk({tag, "/", which, "/IF_flush"},    32'(obs.if_flush),    32'(e.if_flush));
      chk({tag, "/", which, "/ID_EX_flush"}, 32'(obs.id_ex_flush), 32'(e.id_ex_flush));
      chk({tag, "/", which, "/pipe_freeze"}, 32'(obs.pipe_freeze), 32'(e.pipe_freeze));
      chk({tag, "/", which, "/ctrl_state"},  32'(obs.state),       32'(e.state));
   endtask

   // One cycle: drive at negedge, queue expectations, compare 2 ns later.
   // rst holds reset through the next edge; pulse drops it only around the check.
   task automatic step(input logic [6:0] op, input logic [4:0] s1, input logic [4:0] s2,
                       input logic mr, input logic [4:0] d, input logic bt,
                       input logic imr, input logic dq, input logic dr,
                       input bit rst, input bit pulse, input string tag);
      exp_t e1, e3;
      int   n1, n3;
      bit   init_eff;
      @(negedge clk);
      opcode = op; rs1 = s1; rs2 = s2; mem_read = mr; rd = d;
      branch_taken = bt; imem_ready = imr; dmem_req = dq; dmem_ready = dr;
      reset_n = (rst || pulse) ? 1'b0 : 1'b1;
      init_eff = init_m || rst || pulse;
      e1 = model(init_eff, rem1, 1, n1);
      e3 = model(init_eff, rem3, 3, n3);
      sb.push_back(e1);
      sb.push_back(e3);
      #2;
      check_dut(tag, "lat1", {pcw1, ifw1, iff1, idf1, frz1, st1});
      check_dut(tag, "lat3", {pcw3, ifw3, iff3, idf3, frz3, st3});
`ifdef RISCV_HAZARD_PERF_EN
      if (pulse) begin
         chk({tag, "/perf_lu1"}, plu1, 32'd0);
         chk({tag, "/perf_fl1"}, pfl1, 32'd0);
         chk({tag, "/perf_fz1"}, pfz1, 32'd0);
         chk({tag, "/perf_lu3"}, plu3, 32'd0);
         chk({tag, "/perf_fl3"}, pfl3, 32'd0);
         chk({tag, "/perf_fz3"}, pfz3, 32'd0);
      end
`endif
      if (pulse) reset_n = 1'b1;
      rem1   = init_eff ? 0 : n1;
      rem3   = init_eff ? 0 : n3;
      init_m = rst;
   endtask

   initial begin
      reset_n = 1'b0;
      opcode = ADDI; rs1 = '0; rs2 = '0; rd = '0; mem_read = 1'b0;
      branch_taken = 1'b0; imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
      init_m = 1'b1; rem1 = 0; rem3 = 0;

      //   op    rs1 rs2 mr rd bt imr dq dr rst pulse tag
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, "rst_hold");
      step(ADDI, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, "rst_freeze");
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "cycle1");
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "cycle2");
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "cycle3");

      // ADD x?, x1, x5 behind a load to x5
      step(ADD,  1, 5, 1, 5, 0, 1, 0, 0, 0, 0, "lu_add");
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "lu_after1");
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "lu_after2");
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "lu_after3");
      step(LUI,  5, 5, 1, 5, 0, 1, 0, 0, 0, 0, "lui_no_lu");
      step(ADD,  0, 0, 1, 0, 0, 1, 0, 0, 0, 0, "rd_zero");

      // Freeze on the second stall cycle extends the stall by one
      step(ADDI, 5, 0, 1, 5, 0, 1, 0, 0, 0, 0, "lu3_start");
      step(ADDI, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, "lu3_freeze");
      step(ADDI, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, "lu3_s2");
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "lu3_s3");
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "lu3_done");

      // Branch beats a simultaneous load-use, and aborts a running stall
      step(ADD,  1, 5, 1, 5, 1, 1, 0, 0, 0, 0, "bt_with_lu");
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "bt_with_lu_after");
      step(ADD,  5, 2, 1, 5, 0, 1, 0, 0, 0, 0, "lu4");
      step(ADDI, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, "bt_in_stall");
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "bt_stall_after");

      // Freeze outranks a branch
      step(ADDI, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, "freeze_bt");
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "freeze_bt_after");

      // Two fetch misses
      step(ADDI, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "imem_miss_a");
      step(ADDI, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "imem_miss_b");
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "imem_back");

      // Asynchronous reset while the LOAD_LAT=3 instance is mid-stall
      step(ADD,  5, 5, 1, 5, 0, 1, 0, 0, 0, 0, "lu5");
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, "rst_pulse");
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "post_pulse1");
      step(ADDI, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "post_pulse2");

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
